// File: rtl/multicycle_core.sv
// multicycle_core: multi-cycle RV64-subset processor core.
// One FSM walks each instruction through FETCH/DECODE/EXEC/MEM/WB and shares
// a single ALU and a 32 x XLEN register file. Instruction and data memories
// are external, behind req/ready handshakes, so wait states are supported.
// Supported: add/sub/and/or, addi, ld, sd, beq. Anything else halts the core.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   imem_req/addr       fetch request (combinational from state) and PC
//   imem_ready/rdata    fetch completes; instruction word
//   dmem_req/we         data request (combinational from state), 1 = store
//   dmem_addr/wdata     ALU result address, rs2 store data
//   dmem_ready/rdata    data access completes; load data
//   retire              one-cycle pulse in the cycle whose edge commits
//   halt                sticky; unsupported instruction seen
//   pc_out              current PC
//   cycle_cnt, instret_cnt  performance counters, present only when
//                       MULTICYCLE_CORE_PERFCNT_EN is defined
module multicycle_core #(
  parameter int unsigned       XLEN     = 64,
  parameter int unsigned       ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_ready,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              retire,
  output logic              halt,
  output logic [ADDR_W-1:0] pc_out
`ifdef MULTICYCLE_CORE_PERFCNT_EN
  ,
  output logic [31:0]       cycle_cnt,
  output logic [31:0]       instret_cnt
`endif
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_SD   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d, imm_q, imm_d;
  logic [XLEN-1:0]   alu_q, alu_d, mdr_q, mdr_d;
  logic [XLEN-1:0]   rf_q [32];

  logic              rf_we;
  logic [XLEN-1:0]   rf_wdata;
  logic              retire_c;

  // Instruction field decode from the latched IR
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd, rs1, rs2;
  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign funct3 = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign funct7 = ir_q[31:25];

  logic is_r, is_addi, is_ld, is_sd, is_beq, is_valid;
  assign is_r = (opcode == OP_R) &&
                (((funct7 == 7'b0000000) &&
                  ((funct3 == 3'b000) || (funct3 == 3'b110) || (funct3 == 3'b111))) ||
                 ((funct7 == 7'b0100000) && (funct3 == 3'b000)));
  assign is_addi  = (opcode == OP_ADDI) && (funct3 == 3'b000);
  assign is_ld    = (opcode == OP_LD)   && (funct3 == 3'b011);
  assign is_sd    = (opcode == OP_SD)   && (funct3 == 3'b011);
  assign is_beq   = (opcode == OP_BEQ)  && (funct3 == 3'b000);
  assign is_valid = is_r || is_addi || is_ld || is_sd || is_beq;

  // Sign-extended I/S/B immediates
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_gen;
  assign imm_i   = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
  assign imm_s   = {{(XLEN-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b   = {{(XLEN-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_gen = is_sd ? imm_s : (is_beq ? imm_b : imm_i);

  // Register file read ports; x0 always reads zero
  logic [XLEN-1:0] rs1_val, rs2_val;
  assign rs1_val = (rs1 == 5'd0) ? '0 : rf_q[rs1];
  assign rs2_val = (rs2 == 5'd0) ? '0 : rf_q[rs2];

  // Shared ALU: R-type ops on A/B, everything else is A + imm
  logic [XLEN-1:0] alu_res;
  always_comb begin
    alu_res = a_q + imm_q;
    if (is_r) begin
      if (funct3 == 3'b110)      alu_res = a_q | b_q;
      else if (funct3 == 3'b111) alu_res = a_q & b_q;
      else if (funct7[5])        alu_res = a_q - b_q;
      else                       alu_res = a_q + b_q;
    end
  end

  logic [ADDR_W-1:0] pc_plus4, br_target;
  assign pc_plus4  = pc_q + ADDR_W'(4);
  assign br_target = pc_q + ADDR_W'(imm_q);

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    imm_d    = imm_q;
    alu_d    = alu_q;
    mdr_d    = mdr_q;
    rf_we    = 1'b0;
    rf_wdata = alu_q;
    retire_c = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        if (imem_ready) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d     = rs1_val;
        b_d     = rs2_val;
        imm_d   = imm_gen;
        state_d = is_valid ? S_EXEC : S_HALT;
      end
      S_EXEC: begin
        alu_d = alu_res;
        if (is_beq) begin
          pc_d     = (a_q == b_q) ? br_target : pc_plus4;
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end else if (is_ld || is_sd) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (dmem_ready) begin
          if (is_ld) begin
            mdr_d   = dmem_rdata;
            state_d = S_WB;
          end else begin
            pc_d     = pc_plus4;
            retire_c = 1'b1;
            state_d  = S_FETCH;
          end
        end
      end
      S_WB: begin
        rf_we    = (rd != 5'd0);
        rf_wdata = is_ld ? mdr_q : alu_q;
        pc_d     = pc_plus4;
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  // State, datapath latches and register file; reset wins over any commit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      imm_q   <= imm_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
      if (rf_we) rf_q[rd] <= rf_wdata;
    end
  end

  // Requests and pulses are gated by rst_n so nothing leaks out during reset
  assign imem_req   = rst_n && (state_q == S_FETCH);
  assign imem_addr  = pc_q;
  assign dmem_req   = rst_n && (state_q == S_MEM);
  assign dmem_we    = (state_q == S_MEM) && is_sd;
  assign dmem_addr  = alu_q;
  assign dmem_wdata = b_q;
  assign retire     = rst_n && retire_c;
  assign halt       = rst_n && (state_q == S_HALT);
  assign pc_out     = pc_q;

`ifdef MULTICYCLE_CORE_PERFCNT_EN
  // Cycle counter freezes once halted; instret counts commits
  logic [31:0] cycle_cnt_q, cycle_cnt_d, instret_cnt_q, instret_cnt_d;
  always_comb begin
    cycle_cnt_d   = cycle_cnt_q;
    instret_cnt_d = instret_cnt_q;
    if (state_q != S_HALT) cycle_cnt_d = cycle_cnt_q + 32'd1;
    if (retire_c)          instret_cnt_d = instret_cnt_q + 32'd1;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
    end
  end
  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_core.sv
// Testbench for multicycle_core: directed programs plus randomized programs,
// all checked against an instruction-level reference model and a memory
// image. Memories respond with fixed or random wait states.
module tb_multicycle_core;
  localparam int unsigned XLEN   = 64;
  localparam int unsigned ADDR_W = 8;
  localparam logic [7:0]  RPC    = 8'h10;

  logic              clk, rst_n;
  logic              imem_req, imem_ready;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              dmem_req, dmem_we, dmem_ready;
  logic [XLEN-1:0]   dmem_addr, dmem_wdata, dmem_rdata;
  logic              retire, halt;
  logic [ADDR_W-1:0] pc_out;
`ifdef MULTICYCLE_CORE_PERFCNT_EN
  logic [31:0]       cycle_cnt, instret_cnt;
`endif

  multicycle_core #(.XLEN(XLEN), .ADDR_W(ADDR_W), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .retire(retire), .halt(halt), .pc_out(pc_out)
`ifdef MULTICYCLE_CORE_PERFCNT_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] imem [64];
  logic [63:0] dmem [64];
  logic [63:0] m_mem [64];
  logic [63:0] m_reg [32];
  int          rq[$];
  logic [7:0]  fq[$];
  logic [8:0]  dq[$];
  int          cyc, iw_cnt, iw_tgt, dw_cnt, dw_tgt, iw_fix, dw_fix, stab_err;
  bit          rand_w, dact;
  logic [63:0] da;
  logic        dwe;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int nxt(input int fix);
    return rand_w ? int'($urandom_range(0, 2)) : fix;
  endfunction

  function automatic int get_rq(input int i);
    return (rq.size() > i) ? rq[i] : -1;
  endfunction
  function automatic logic [7:0] get_fq(input int i);
    return (fq.size() > i) ? fq[i] : 8'hxx;
  endfunction
  function automatic logic [8:0] get_dq(input int i);
    return (dq.size() > i) ? dq[i] : 9'h1ff;
  endfunction

  // Instruction encoders
  function automatic logic [31:0] e_r(input logic [6:0] f7, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] e_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction
  function automatic logic [31:0] e_ld(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b011, rd, 7'b0000011};
  endfunction
  function automatic logic [31:0] e_sd(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] e_beq(input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] off);
    return {off[12], off[10:5], rs2, rs1, 3'b000, off[4:1], off[11], 7'b1100011};
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) imem[i] = 32'd0;
  endtask
  task automatic put(input logic [7:0] addr, input logic [31:0] ins);
    imem[addr[7:2]] = ins;
  endtask

  // Instruction-level reference: architectural effect plus zero-wait latency
  task automatic model_run(input logic [7:0] pc0, output int n_ret, output logic [7:0] hpc, output int lat);
    logic [7:0]  pc;
    logic [31:0] ins;
    logic [63:0] a, b, ii, si, bi, res, ea;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        wr;
    pc = pc0; n_ret = 0; lat = 0; hpc = pc0;
    for (int s = 0; s < 1000; s++) begin
      ins = imem[pc[7:2]];
      op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25]; rd = ins[11:7];
      a  = m_reg[ins[19:15]];
      b  = m_reg[ins[24:20]];
      ii = 64'($signed(ins[31:20]));
      si = 64'($signed({ins[31:25], ins[11:7]}));
      bi = 64'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      wr = 1'b0; res = '0;
      if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd0)      begin res = a + b; wr = 1'b1; lat += 4; end
      else if (op == 7'h33 && f7 == 7'h20 && f3 == 3'd0) begin res = a - b; wr = 1'b1; lat += 4; end
      else if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd7) begin res = a & b; wr = 1'b1; lat += 4; end
      else if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd6) begin res = a | b; wr = 1'b1; lat += 4; end
      else if (op == 7'h13 && f3 == 3'd0)                begin res = a + ii; wr = 1'b1; lat += 4; end
      else if (op == 7'h03 && f3 == 3'd3) begin
        ea = a + ii; res = m_mem[ea[8:3]]; wr = 1'b1; lat += 5;
      end else if (op == 7'h23 && f3 == 3'd3) begin
        ea = a + si; m_mem[ea[8:3]] = b; lat += 4;
      end else if (op == 7'h63 && f3 == 3'd0) begin
        lat += 3; n_ret++;
        pc = (a == b) ? pc + bi[7:0] : pc + 8'd4;
        continue;
      end else begin
        hpc = pc;
        return;
      end
      if (wr && rd != 5'd0) m_reg[rd] = res;
      n_ret++;
      pc = pc + 8'd4;
    end
  endtask

  // One clock: apply reset value, answer handshakes, then observe
  task automatic cycle(input logic r);
    @(posedge clk);
    #1;
    rst_n = r;
    #1;
    if (imem_req) begin
      imem_rdata = imem[imem_addr[7:2]];
      if (iw_cnt < iw_tgt) begin imem_ready = 1'b0; iw_cnt++; end
      else imem_ready = 1'b1;
    end else begin
      imem_ready = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
    end
    if (dmem_req && dw_cnt >= dw_tgt) begin
      dmem_ready = 1'b1;
      dmem_rdata = dmem[dmem_addr[8:3]];
    end else begin
      if (dmem_req) dw_cnt++;
      dmem_ready = dmem_req ? 1'b0 : 1'($urandom_range(0, 1));
      dmem_rdata = {$urandom, $urandom};
    end
    #1;
    if (r) begin
      cyc++;
      if (retire) rq.push_back(cyc);
      if (imem_req && imem_ready) begin
        fq.push_back(imem_addr);
        iw_cnt = 0; iw_tgt = nxt(iw_fix);
      end
      if (dmem_req) begin
        if (!dact) begin dact = 1'b1; da = dmem_addr; dwe = dmem_we; end
        else if (da !== dmem_addr || dwe !== dmem_we) stab_err++;
      end
      if (dmem_req && dmem_ready) begin
        dq.push_back({dmem_we, dmem_addr[7:0]});
        if (dmem_we) dmem[dmem_addr[8:3]] = dmem_wdata;
        dact = 1'b0; dw_cnt = 0; dw_tgt = nxt(dw_fix);
      end
    end
  endtask

  // Reset, run the loaded program to halt, compare against the model
  task automatic run_prog(input string tag, input int max_cyc, input bit chk_cyc);
    int         exp_ret, exp_lat, hcyc;
    logic [7:0] exp_hpc;
    logic       req_seen;
    for (int i = 0; i < 64; i++) begin dmem[i] = {$urandom, $urandom}; m_mem[i] = dmem[i]; end
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
    model_run(RPC, exp_ret, exp_hpc, exp_lat);
    rq.delete(); fq.delete(); dq.delete();
    cycle(1'b0);
    cycle(1'b0);
    check({tag, ":rst_req"}, {62'd0, imem_req, dmem_req}, 64'd0);
    iw_cnt = 0; dw_cnt = 0; dact = 1'b0; stab_err = 0; cyc = 0;
    iw_tgt = nxt(iw_fix); dw_tgt = nxt(dw_fix);
    cycle(1'b1);
    check({tag, ":first_fetch"}, {55'd0, imem_req, imem_addr}, {55'd0, 1'b1, RPC});
    check({tag, ":first_ret_halt"}, {62'd0, retire, halt}, 64'd0);
    while (!halt && cyc < max_cyc) cycle(1'b1);
    hcyc = cyc;
    check({tag, ":halted"}, 64'(halt), 64'd1);
    if (chk_cyc) check({tag, ":halt_cycle"}, 64'(hcyc), 64'(exp_lat + 3));
    req_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1);
      req_seen = req_seen | imem_req | dmem_req;
    end
    check({tag, ":halt_quiet"}, 64'(req_seen), 64'd0);
    check({tag, ":halt_pc"}, 64'(pc_out), 64'(exp_hpc));
    check({tag, ":retire_count"}, 64'(rq.size()), 64'(exp_ret));
    check({tag, ":dmem_stable"}, 64'(stab_err), 64'd0);
    for (int i = 0; i < 64; i++) check({tag, ":dmem"}, dmem[i], m_mem[i]);
`ifdef MULTICYCLE_CORE_PERFCNT_EN
    check({tag, ":instret_cnt"}, 64'(instret_cnt), 64'(exp_ret));
    check({tag, ":cycle_cnt"}, 64'(cycle_cnt), 64'(hcyc - 1));
`endif
  endtask

  task automatic gen_random();
    int          n, k, j, sel;
    logic [4:0]  rd, rs1, rs2;
    logic [6:0]  f7s [4];
    logic [2:0]  f3s [4];
    f7s[0] = 7'h00; f3s[0] = 3'd0;
    f7s[1] = 7'h20; f3s[1] = 3'd0;
    f7s[2] = 7'h00; f3s[2] = 3'd7;
    f7s[3] = 7'h00; f3s[3] = 3'd6;
    clear_imem();
    n = 16;
    for (k = 0; k < n; k++) begin
      sel = $urandom_range(0, 5);
      rd  = 5'($urandom_range(0, 7));
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      case (sel)
        1: begin j = $urandom_range(0, 3); imem[4 + k] = e_r(f7s[j], f3s[j], rd, rs1, rs2); end
        2: imem[4 + k] = e_ld(rd, 5'd0, 12'(8 * $urandom_range(0, 31)));
        3: imem[4 + k] = e_sd(rs2, 5'd0, 12'(8 * $urandom_range(0, 31)));
        4: begin
          j = $urandom_range(1, (n - k) < 3 ? (n - k) : 3);
          imem[4 + k] = e_beq(rs1, rs2, 13'(4 * j));
        end
        default: imem[4 + k] = e_addi(rd, rs1, 12'($urandom));
      endcase
    end
    for (int i = 1; i < 8; i++) imem[4 + n + i - 1] = e_sd(5'(i), 5'd0, 12'(256 + 8 * i));
  endtask

  initial begin
    rst_n = 1'b0; imem_ready = 1'b0; imem_rdata = '0; dmem_ready = 1'b0; dmem_rdata = '0;
    rand_w = 1'b0; iw_fix = 0; dw_fix = 0;

    // ALU sequence, retire cadence
    clear_imem();
    put(8'h10, e_addi(5'd1, 5'd0, 12'd5));
    put(8'h14, e_addi(5'd2, 5'd0, 12'hFFD));
    put(8'h18, e_r(7'h00, 3'd0, 5'd3, 5'd1, 5'd2));
    put(8'h1C, e_r(7'h20, 3'd0, 5'd4, 5'd2, 5'd1));
    put(8'h20, e_sd(5'd3, 5'd0, 12'd0));
    put(8'h24, e_sd(5'd4, 5'd0, 12'd8));
    run_prog("alu", 500, 1'b1);
    check("alu:x3", dmem[0], 64'd2);
    check("alu:x4", dmem[1], 64'hFFFF_FFFF_FFFF_FFF8);
    for (int i = 0; i < 4; i++) check("alu:retire_at", 64'(get_rq(i)), 64'(4 * (i + 1)));

    // x0 writes discarded, store then load
    clear_imem();
    put(8'h10, e_addi(5'd1, 5'd0, 12'd5));
    put(8'h14, e_addi(5'd0, 5'd0, 12'd7));
    put(8'h18, e_r(7'h00, 3'd0, 5'd5, 5'd0, 5'd0));
    put(8'h1C, e_sd(5'd1, 5'd0, 12'd8));
    put(8'h20, e_ld(5'd6, 5'd0, 12'd8));
    put(8'h24, e_sd(5'd5, 5'd0, 12'd16));
    put(8'h28, e_sd(5'd6, 5'd0, 12'd24));
    run_prog("x0ldsd", 500, 1'b1);
    check("x0ldsd:acc0", 64'(get_dq(0)), 64'h108);
    check("x0ldsd:acc1", 64'(get_dq(1)), 64'h008);
    check("x0ldsd:x5", dmem[2], 64'd0);
    check("x0ldsd:x6", dmem[3], 64'd5);

    // Wait states: 3 on every fetch, 2 on every data access
    iw_fix = 3; dw_fix = 2;
    clear_imem();
    put(8'h10, e_ld(5'd7, 5'd0, 12'd16));
    put(8'h14, e_sd(5'd7, 5'd0, 12'd24));
    run_prog("wait", 500, 1'b0);
    check("wait:ld_retire", 64'(get_rq(0)), 64'd10);
    iw_fix = 0; dw_fix = 0;

    // Branches: not taken, long forward, PC wrap
    clear_imem();
    put(8'h10, e_addi(5'd1, 5'd0, 12'd5));
    put(8'h14, e_addi(5'd2, 5'd0, 12'd6));
    put(8'h18, e_beq(5'd1, 5'd2, 13'd8));
    put(8'h1C, e_beq(5'd0, 5'd0, 13'h0E0));
    put(8'hFC, e_beq(5'd1, 5'd1, 13'd8));
    put(8'h04, e_sd(5'd1, 5'd0, 12'd0));
    run_prog("beq", 500, 1'b1);
    check("beq:not_taken", 64'(get_fq(3)), 64'h1C);
    check("beq:far", 64'(get_fq(4)), 64'hFC);
    check("beq:wrap", 64'(get_fq(5)), 64'h04);
    check("beq:ret0", 64'(get_rq(2)), 64'd11);
    check("beq:ret1", 64'(get_rq(3)), 64'd14);
    check("beq:ret2", 64'(get_rq(4)), 64'd17);

    // Random programs, alternating zero-wait and random-wait memories
    for (int t = 0; t < 8; t++) begin
      rand_w = 1'(t % 2);
      gen_random();
      run_prog("rand", 3000, !rand_w);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
